unidade_temporizacao: RTL and testbench

- Timing scheduler for the memory-game datapath. Sequences the three game timers: LED-on time, LED-off gap and player-response timeout.
- Watches the state flags from the game control unit (estado_ledsOn, estado_ledsOff, estado_espera). Returns the completion signals fimLedsOn, fimLedsOff and timeout.
- Durations are computed per request. When acceleration is enabled, they shrink as the round number grows, down to a fixed floor.
- One shared down-counter serves all three timers, so only one timer is ever active.

---
 rtl/unidade_temporizacao.sv | 152 +++++++++++++++
 tb/tb_unidade_temporizacao.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/unidade_temporizacao.sv
// Timing scheduler for the memory game: sequences LED-on, LED-off and response
// timers on one shared down-counter, with per-round shrinking of on/off times.
module unidade_temporizacao #(
    parameter int LARGURA     = 16,
    parameter int T_ON_BASE   = 1000,
    parameter int T_ON_MIN    = 200,
    parameter int T_ON_PASSO  = 50,
    parameter int T_OFF_BASE  = 500,
    parameter int T_OFF_MIN   = 100,
    parameter int T_OFF_PASSO = 25,
    parameter int T_TIMEOUT   = 5000
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               estado_ledsOn,
    input  logic               estado_ledsOff,
    input  logic               estado_espera,
    input  logic               acelera,
    input  logic [3:0]         rodada,
    output logic               fimLedsOn,
    output logic               fimLedsOff,
    output logic               timeout,
    output logic [LARGURA-1:0] db_contagem,
    output logic [2:0]         db_estado
);

    typedef enum logic [2:0] {
        OCIOSO    = 3'd0,
        CONTA_ON  = 3'd1,
        FIM_ON    = 3'd2,
        CONTA_OFF = 3'd3,
        FIM_OFF   = 3'd4,
        CONTA_ESP = 3'd5,
        FIM_ESP   = 3'd6
    } estado_t;

    localparam int                 LW = LARGURA + 4;
    localparam logic [LARGURA-1:0] UM = LARGURA'(1);

    // Index 0 = LED-on, 1 = LED-off, 2 = response timeout.
    logic [2:0][LARGURA-1:0] duracao;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : gDuracao
            localparam int BASE   = (gi == 0) ? T_ON_BASE  : T_OFF_BASE;
            localparam int MINIMO = (gi == 0) ? T_ON_MIN   : T_OFF_MIN;
            localparam int PASSO  = (gi == 0) ? T_ON_PASSO : T_OFF_PASSO;

            logic [LW-1:0] baseLarga;
            logic [LW-1:0] produto;
            logic [LW-1:0] diferenca;

            assign baseLarga = LW'(BASE);
            assign produto   = LW'(rodada) * LW'(PASSO);
            assign diferenca = baseLarga - produto;

            // A product larger than the base would wrap, so it saturates to the floor.
            assign duracao[gi] = !acelera ? LARGURA'(BASE)
                               : ((produto > baseLarga) || (diferenca < LW'(MINIMO))) ? LARGURA'(MINIMO)
                               : diferenca[LARGURA-1:0];
        end
    endgenerate

    assign duracao[2] = LARGURA'(T_TIMEOUT);

    estado_t            estadoReg;
    estado_t            estadoNext;
    estado_t            estadoSel;
    logic [LARGURA-1:0] contagemReg;
    logic [LARGURA-1:0] contagemNext;
    logic [LARGURA-1:0] contagemSel;
    logic               pedidoProprio;

    always_ff @(posedge clock) begin
        if (reset) begin
            estadoReg   <= OCIOSO;
            contagemReg <= '0;
        end else begin
            estadoReg   <= estadoNext;
            contagemReg <= contagemNext;
        end
    end

    // Fixed-priority request selection; durations are captured only here.
    always_comb begin
        estadoSel   = OCIOSO;
        contagemSel = '0;
        if (estado_ledsOn) begin
            estadoSel   = CONTA_ON;
            contagemSel = duracao[0] - UM;
        end else if (estado_ledsOff) begin
            estadoSel   = CONTA_OFF;
            contagemSel = duracao[1] - UM;
        end else if (estado_espera) begin
            estadoSel   = CONTA_ESP;
            contagemSel = duracao[2] - UM;
        end
    end

    always_comb begin
        pedidoProprio = 1'b0;
        case (estadoReg)
            CONTA_ON,  FIM_ON:  pedidoProprio = estado_ledsOn;
            CONTA_OFF, FIM_OFF: pedidoProprio = estado_ledsOff;
            CONTA_ESP, FIM_ESP: pedidoProprio = estado_espera;
            default:            pedidoProprio = 1'b0;
        endcase
    end

    always_comb begin
        estadoNext   = estadoSel;
        contagemNext = contagemSel;
        case (estadoReg)
            OCIOSO: begin
                estadoNext   = estadoSel;
                contagemNext = contagemSel;
            end
            CONTA_ON, CONTA_OFF, CONTA_ESP: begin
                if (pedidoProprio) begin
                    if (contagemReg != '0) begin
                        estadoNext   = estadoReg;
                        contagemNext = contagemReg - UM;
                    end else begin
                        contagemNext = '0;
                        case (estadoReg)
                            CONTA_ON:  estadoNext = FIM_ON;
                            CONTA_OFF: estadoNext = FIM_OFF;
                            default:   estadoNext = FIM_ESP;
                        endcase
                    end
                end
            end
            FIM_ON, FIM_OFF, FIM_ESP: begin
                if (pedidoProprio) begin
                    estadoNext   = estadoReg;
                    contagemNext = '0;
                end
            end
            default: begin
                estadoNext   = OCIOSO;
                contagemNext = '0;
            end
        endcase
    end

    assign fimLedsOn   = (estadoReg == FIM_ON);
    assign fimLedsOff  = (estadoReg == FIM_OFF);
    assign timeout     = (estadoReg == FIM_ESP);
    assign db_contagem = contagemReg;
    assign db_estado   = estadoReg;

endmodule

// File: tb/tb_unidade_temporizacao.sv
// Scoreboard bench for unidade_temporizacao: expected completion latencies are
// queued when a request is driven and compared when the matching flag rises.
module tb_unidade_temporizacao;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        estado_ledsOn = 1'b0;
    logic        estado_ledsOff = 1'b0;
    logic        estado_espera = 1'b0;
    logic        acelera = 1'b0;
    logic [3:0]  rodada = 4'd0;
    logic        fimLedsOn;
    logic        fimLedsOff;
    logic        timeout;
    logic [15:0] db_contagem;
    logic [2:0]  db_estado;

    int total = 0;
    int bad = 0;

    typedef struct {
        int kind;
        int lat;
    } esperado_t;

    esperado_t sb[$];

    unidade_temporizacao #(
        .LARGURA    (16),
        .T_ON_BASE  (10),
        .T_ON_MIN   (4),
        .T_ON_PASSO (2),
        .T_OFF_BASE (6),
        .T_OFF_MIN  (3),
        .T_OFF_PASSO(1),
        .T_TIMEOUT  (20)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .estado_ledsOn (estado_ledsOn),
        .estado_ledsOff(estado_ledsOff),
        .estado_espera (estado_espera),
        .acelera       (acelera),
        .rodada        (rodada),
        .fimLedsOn     (fimLedsOn),
        .fimLedsOff    (fimLedsOff),
        .timeout       (timeout),
        .db_contagem   (db_contagem),
        .db_estado     (db_estado)
    );

    always #5 clock = ~clock;

    // Reference durations: 0 = on, 1 = off, 2 = response.
    function automatic int durModel(input int kind, input logic acel, input int rod);
        int base;
        int minimo;
        int passo;
        int d;
        if (kind == 2) return 20;
        base   = (kind == 0) ? 10 : 6;
        minimo = (kind == 0) ? 4 : 3;
        passo  = (kind == 0) ? 2 : 1;
        if (!acel) return base;
        d = base - rod * passo;
        return (d < minimo) ? minimo : d;
    endfunction

    function automatic logic saida(input int kind);
        if (kind == 0) return fimLedsOn;
        if (kind == 1) return fimLedsOff;
        return timeout;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Edges until the selected flag is seen high; -1 if the bound expires.
    task automatic measure(input int kind, input int limite, output int lat);
        lat = -1;
        for (int n = 1; n <= limite; n++) begin
            tick();
            if (saida(kind) === 1'b1) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        total++;
        if ({fimLedsOn, fimLedsOff, timeout} !== 3'b000) begin
            bad++;
            $display("FAIL reset_flags: got %b want 000", {fimLedsOn, fimLedsOff, timeout});
        end
        total++;
        if (db_estado !== 3'd0) begin
            bad++;
            $display("FAIL reset_estado: got %0d want 0", db_estado);
        end
        total++;
        if (db_contagem !== 16'd0) begin
            bad++;
            $display("FAIL reset_contagem: got %0d want 0", db_contagem);
        end
        reset = 1'b0;
        tick();
        total++;
        if (db_estado !== 3'd0) begin
            bad++;
            $display("FAIL idle_after_reset: got %0d want 0", db_estado);
        end
        $display("txn reset estado=%0d contagem=%0d", db_estado, db_contagem);
    endtask

    task automatic test_sem_acelera();
        int lat;
        esperado_t e;
        acelera = 1'b0;
        rodada  = 4'd5;
        estado_ledsOn = 1'b1;
        sb.push_back('{0, durModel(0, 1'b0, 5) + 1});
        measure(0, 60, lat);
        e = sb.pop_front();
        total++;
        if (lat !== e.lat) begin
            bad++;
            $display("FAIL on_fixed_latency: got %0d want %0d", lat, e.lat);
        end
        total++;
        if (db_estado !== 3'd2 || db_contagem !== 16'd0) begin
            bad++;
            $display("FAIL fim_on_state: got estado=%0d contagem=%0d want 2/0", db_estado, db_contagem);
        end
        repeat (3) tick();
        total++;
        if (fimLedsOn !== 1'b1) begin
            bad++;
            $display("FAIL fim_on_hold: got %b want 1", fimLedsOn);
        end
        estado_ledsOn = 1'b0;
        tick();
        total++;
        if (fimLedsOn !== 1'b0 || db_estado !== 3'd0) begin
            bad++;
            $display("FAIL fim_on_release: got fim=%b estado=%0d want 0/0", fimLedsOn, db_estado);
        end
        $display("txn on acelera=0 rodada=5 lat=%0d", lat);
    endtask

    task automatic test_acelera();
        int rods[3] = '{2, 7, 0};
        int lat;
        esperado_t e;
        foreach (rods[i]) begin
            acelera = 1'b1;
            rodada  = 4'(rods[i]);
            estado_ledsOn = 1'b1;
            sb.push_back('{0, durModel(0, 1'b1, rods[i]) + 1});
            measure(0, 60, lat);
            e = sb.pop_front();
            total++;
            if (lat !== e.lat) begin
                bad++;
                $display("FAIL on_accel_r%0d: got %0d want %0d", rods[i], lat, e.lat);
            end
            $display("txn on acelera=1 rodada=%0d lat=%0d", rods[i], lat);
            estado_ledsOn = 1'b0;
            tick();
        end
    endtask

    task automatic test_on_para_off();
        int lat;
        esperado_t e;
        acelera = 1'b1;
        rodada  = 4'd2;
        estado_ledsOn = 1'b1;
        sb.push_back('{0, durModel(0, 1'b1, 2) + 1});
        measure(0, 60, lat);
        e = sb.pop_front();
        total++;
        if (lat !== e.lat) begin
            bad++;
            $display("FAIL on_before_off: got %0d want %0d", lat, e.lat);
        end
        estado_ledsOn  = 1'b0;
        estado_ledsOff = 1'b1;
        tick();
        total++;
        if (db_estado !== 3'd3) begin
            bad++;
            $display("FAIL direct_conta_off: got %0d want 3", db_estado);
        end
        total++;
        if (db_contagem !== 16'(durModel(1, 1'b1, 2) - 1)) begin
            bad++;
            $display("FAIL off_load: got %0d want %0d", db_contagem, durModel(1, 1'b1, 2) - 1);
        end
        sb.push_back('{1, durModel(1, 1'b1, 2)});
        measure(1, 60, lat);
        e = sb.pop_front();
        total++;
        if (lat !== e.lat) begin
            bad++;
            $display("FAIL off_latency: got %0d want %0d", lat, e.lat);
        end
        $display("txn on->off rodada=2 off_lat=%0d", lat);
        estado_ledsOff = 1'b0;
        tick();
    endtask

    task automatic test_espera();
        int lat;
        logic visto;
        esperado_t e;
        acelera = 1'b0;
        rodada  = 4'd3;
        estado_espera = 1'b1;
        visto = 1'b0;
        repeat (10) begin
            tick();
            if (timeout !== 1'b0) visto = 1'b1;
        end
        total++;
        if (visto !== 1'b0) begin
            bad++;
            $display("FAIL esp_early: got 1 want 0");
        end
        estado_espera = 1'b0;
        tick();
        total++;
        if (db_estado !== 3'd0 || timeout !== 1'b0) begin
            bad++;
            $display("FAIL esp_abort: got estado=%0d timeout=%b want 0/0", db_estado, timeout);
        end
        estado_espera = 1'b1;
        sb.push_back('{2, durModel(2, 1'b0, 0) + 1});
        repeat (5) tick();
        rodada  = 4'd9;
        acelera = 1'b1;
        measure(2, 60, lat);
        if (lat >= 0) lat = lat + 5;
        e = sb.pop_front();
        total++;
        if (lat !== e.lat) begin
            bad++;
            $display("FAIL esp_latency: got %0d want %0d", lat, e.lat);
        end
        $display("txn espera lat=%0d", lat);
        estado_espera = 1'b0;
        tick();
    endtask

    task automatic test_reset_meio();
        int lat;
        esperado_t e;
        acelera = 1'b1;
        rodada  = 4'd2;
        estado_ledsOff = 1'b1;
        tick();
        total++;
        if (db_estado !== 3'd3 || db_contagem !== 16'd3) begin
            bad++;
            $display("FAIL pre_reset: got estado=%0d contagem=%0d want 3/3", db_estado, db_contagem);
        end
        reset = 1'b1;
        estado_ledsOff = 1'b0;
        estado_ledsOn  = 1'b1;
        tick();
        total++;
        if ({fimLedsOn, fimLedsOff, timeout} !== 3'b000 || db_estado !== 3'd0) begin
            bad++;
            $display("FAIL mid_reset_state: got flags=%b estado=%0d want 000/0",
                     {fimLedsOn, fimLedsOff, timeout}, db_estado);
        end
        total++;
        if (db_contagem !== 16'd0) begin
            bad++;
            $display("FAIL mid_reset_contagem: got %0d want 0", db_contagem);
        end
        reset = 1'b0;
        sb.push_back('{0, durModel(0, 1'b1, 2) + 1});
        measure(0, 60, lat);
        e = sb.pop_front();
        total++;
        if (lat !== e.lat) begin
            bad++;
            $display("FAIL post_reset_on: got %0d want %0d", lat, e.lat);
        end
        $display("txn reset_release on lat=%0d", lat);
        estado_ledsOn = 1'b0;
        tick();
    endtask

    task automatic test_prioridade();
        int lat;
        esperado_t e;
        acelera = 1'b0;
        estado_ledsOn = 1'b1;
        estado_espera = 1'b1;
        tick();
        total++;
        if (db_estado !== 3'd1) begin
            bad++;
            $display("FAIL priority_select: got %0d want 1", db_estado);
        end
        sb.push_back('{0, durModel(0, 1'b0, 0)});
        measure(0, 60, lat);
        e = sb.pop_front();
        total++;
        if (lat !== e.lat) begin
            bad++;
            $display("FAIL priority_latency: got %0d want %0d", lat, e.lat);
        end
        total++;
        if (timeout !== 1'b0) begin
            bad++;
            $display("FAIL priority_timeout: got %b want 0", timeout);
        end
        $display("txn priority on+espera lat=%0d", lat);
        estado_ledsOn = 1'b0;
        estado_espera = 1'b0;
        tick();
        total++;
        if (db_estado !== 3'd0) begin
            bad++;
            $display("FAIL priority_release: got %0d want 0", db_estado);
        end
    endtask

    initial begin
        test_reset();
        test_sem_acelera();
        test_acelera();
        test_on_para_off();
        test_espera();
        test_reset_meio();
        test_prioridade();
        total++;
        if (sb.size() !== 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
